// File: rtl/sq_arbiter_pkg.sv
// Shared types and constants for the square-datapath arbiter.
// State encoding, timeout default and the quiet-NaN abort payload.
package sq_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] QNAN_CONST      = 32'h7FC00000;
    localparam int unsigned TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/sq_rr_arb.sv
// Two-way round-robin grant; last names the requester served most recently.
// Output is one-hot, or zero when disabled or nothing is requested.
module sq_rr_arb
    import sq_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11)
                grant = last ? 2'b01 : 2'b10;
            else
                grant = req;
        end
    end

endmodule

// File: rtl/sq_arbiter.sv
// Two-requester front end for a shared square datapath, one op in flight.
// Optional WAIT watchdog enabled by defining SQ_ARB_TIMEOUT_EN.
module sq_arbiter
    import sq_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_A0,
    input  logic [31:0] req_A1,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_overflow,
    output logic        resp_underflow,
    output logic        resp_err,
    output logic [31:0] dp_A,
    output logic        dp_start,
    input  logic        dp_done,
    input  logic [31:0] dp_result,
    input  logic        dp_overflow,
    input  logic        dp_underflow
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_chk
        $error("TIMEOUT_CYCLES out of range");
    end

    state_t      state_q, state_d;
    logic [1:0]  grant;
    logic [31:0] op_q;
    logic        g_q;
    logic        last_q;
    logic [31:0] res_q;
    logic        ovf_q;
    logic        unf_q;
    logic        expire;
    logic        in_wait;
    logic        hs;

    assign in_wait = (state_q == S_WAIT);
    assign hs      = (state_q == S_RESP) && resp_ready[g_q];

    sq_rr_arb u_arb (
        .req   (req_valid),
        .last  (last_q),
        .en    ((state_q == S_IDLE) && !RST),
        .grant (grant)
    );

`ifdef SQ_ARB_TIMEOUT_EN
    localparam logic [16:0] TMO = {1'b0, 16'(TIMEOUT_CYCLES)};

    logic [15:0] cnt_q;
    logic        err_q;

    // expire in the WAIT cycle that brings the count up to TIMEOUT_CYCLES
    assign expire = in_wait && (({1'b0, cnt_q} + 17'd1) == TMO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)
                cnt_q <= '0;
            else if (in_wait)
                cnt_q <= cnt_q + 16'd1;
            if (in_wait && dp_done)
                err_q <= 1'b0;
            else if (expire)
                err_q <= 1'b1;
        end
    end

    assign resp_err = !RST && err_q;
`else
    assign expire   = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|grant) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (dp_done || expire) state_d = S_RESP;
            S_RESP:  if (hs) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            op_q    <= '0;
            g_q     <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (|grant) begin
                op_q <= grant[0] ? req_A0 : req_A1;
                g_q  <= grant[1];
            end
            if (in_wait && dp_done) begin
                res_q <= dp_result;
                ovf_q <= dp_overflow;
                unf_q <= dp_underflow;
            end else if (expire) begin
                res_q <= QNAN_CONST;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (hs)
                last_q <= g_q;
        end
    end

    assign req_ready = grant;
    assign dp_start  = !RST && (state_q == S_ISSUE);
    assign dp_A      = (!RST && (state_q == S_ISSUE || in_wait))
                       ? op_q : '0;

    always_comb begin
        resp_valid = 2'b00;
        if (!RST && state_q == S_RESP)
            resp_valid = g_q ? 2'b10 : 2'b01;
    end

    assign resp_result    = RST ? '0 : res_q;
    assign resp_overflow  = !RST && ovf_q;
    assign resp_underflow = !RST && unf_q;

endmodule

// File: tb/tb_sq_arbiter.sv
// Randomised bench for sq_arbiter with a transaction-level model.
// Drives inputs on the falling edge, samples just after it.
module tb_sq_arbiter;

`ifdef SQ_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1023;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req_valid;
    logic [31:0] req_A0, req_A1;
    logic [1:0]  req_ready, resp_valid, resp_ready;
    logic [31:0] resp_result, dp_A, dp_result;
    logic        resp_overflow, resp_underflow, resp_err;
    logic        dp_start, dp_done, dp_overflow, dp_underflow;

    int n_chk  = 0;
    int n_pass = 0;
    int last_srv;

    sq_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_A0         (req_A0),
        .req_A1         (req_A1),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_result    (resp_result),
        .resp_overflow  (resp_overflow),
        .resp_underflow (resp_underflow),
        .resp_err       (resp_err),
        .dp_A           (dp_A),
        .dp_start       (dp_start),
        .dp_done        (dp_done),
        .dp_result      (dp_result),
        .dp_overflow    (dp_overflow),
        .dp_underflow   (dp_underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [1:0] onehot(input int g);
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    // one full transaction; dly = WAIT cycles before dp_done,
    // hold = RESP cycles with the owner's resp_ready low
    task automatic do_op(input logic [1:0] rv, input logic [31:0] a0,
                         input logic [31:0] res, input int dly,
                         input int hold, input bit spur);
        logic [31:0] a1, opnd;
        logic        ov, un;
        int          g;
        a1   = $urandom;
        ov   = 1'($urandom);
        un   = 1'($urandom);
        g    = (rv == 2'b11) ? (last_srv == 1 ? 0 : 1) : (rv[0] ? 0 : 1);
        opnd = (g == 0) ? a0 : a1;

        @(negedge CLK);
        req_valid  = rv;
        req_A0     = a0;
        req_A1     = a1;
        resp_ready = 2'b00;
        dp_done    = spur;
        dp_result  = ~res;
        #1 check("grant", 32'(req_ready), 32'(onehot(g)));

        @(negedge CLK);
        check("issue_start", 32'(dp_start), 32'd1);
        check("issue_A", dp_A, opnd);
        check("issue_rdy", 32'(req_ready), 32'd0);

        @(negedge CLK);
        dp_done = 1'b0;
        check("wait_start", 32'(dp_start), 32'd0);
        for (int i = 0; i < dly; i++) begin
            check("wait_A", dp_A, opnd);
            check("wait_rv", 32'(resp_valid), 32'd0);
            @(negedge CLK);
        end
        dp_done      = 1'b1;
        dp_result    = res;
        dp_overflow  = ov;
        dp_underflow = un;

        @(negedge CLK);
        dp_done      = 1'b0;
        dp_result    = $urandom;
        dp_overflow  = ~ov;
        dp_underflow = ~un;
        #1;
        check("resp_valid", 32'(resp_valid), 32'(onehot(g)));
        check("resp_result", resp_result, res);
        check("resp_flags", {29'd0, resp_overflow, resp_underflow, resp_err},
              {29'd0, ov, un, 1'b0});

        for (int i = 0; i < hold; i++) begin
            resp_ready = (g == 0) ? 2'b10 : 2'b01;
            @(negedge CLK);
            #1;
            check("hold_valid", 32'(resp_valid), 32'(onehot(g)));
            check("hold_result", resp_result, res);
            check("hold_rdy", 32'(req_ready), 32'd0);
        end
        resp_ready = onehot(g);
        #1 check("hs_rdy", 32'(req_ready), 32'd0);
        @(posedge CLK);
        last_srv = g;
        #1;
        resp_ready = 2'b00;
        req_valid  = 2'b00;
    endtask

    task automatic reset_mid_op();
        @(negedge CLK);
        req_valid = 2'b10;
        req_A1    = $urandom;
        #1 check("rst_grant", 32'(req_ready), 32'(onehot(1)));
        @(negedge CLK);
        req_valid = 2'b00;
        @(negedge CLK);
        RST       = 1'b1;
        req_valid = 2'b11;
        @(negedge CLK);
        #1;
        check("rst_rdy", 32'(req_ready), 32'd0);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_start", 32'(dp_start), 32'd0);
        check("rst_A", dp_A, 32'd0);
        check("rst_res", resp_result, 32'd0);
        req_valid = 2'b00;
        RST       = 1'b0;
        dp_done   = 1'b1;
        dp_result = $urandom;
        @(negedge CLK);
        dp_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("late_rv", 32'(resp_valid), 32'd0);
            check("late_start", 32'(dp_start), 32'd0);
            @(negedge CLK);
        end
        last_srv = 1;
    endtask

`ifdef SQ_ARB_TIMEOUT_EN
    task automatic timeout_op();
        int n;
        @(negedge CLK);
        req_valid = 2'b01;
        req_A0    = $urandom;
        @(negedge CLK);
        req_valid = 2'b00;
        n = 0;
        while (n < 40) begin
            @(negedge CLK);
            #1;
            if (resp_valid != 2'b00) break;
            n++;
        end
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_valid", 32'(resp_valid), 32'd1);
        check("tmo_result", resp_result, 32'h7FC00000);
        check("tmo_err", 32'(resp_err), 32'd1);
        resp_ready = 2'b01;
        @(posedge CLK);
        last_srv = 0;
        #1 resp_ready = 2'b00;
    endtask
`endif

    initial begin
        RST          = 1'b1;
        req_valid    = 2'b11;
        req_A0       = 32'h1234_5678;
        req_A1       = 32'h9ABC_DEF0;
        resp_ready   = 2'b00;
        dp_done      = 1'b0;
        dp_result    = '0;
        dp_overflow  = 1'b0;
        dp_underflow = 1'b0;
        last_srv     = 1;
        repeat (2) @(negedge CLK);
        #1;
        check("reset_rdy", 32'(req_ready), 32'd0);
        check("reset_rv", 32'(resp_valid), 32'd0);
        check("reset_start", 32'(dp_start), 32'd0);
        check("reset_A", dp_A, 32'd0);
        check("reset_res", resp_result, 32'd0);
        check("reset_flags",
              {29'd0, resp_overflow, resp_underflow, resp_err}, 32'd0);
        req_valid = 2'b00;
        @(negedge CLK);
        RST = 1'b0;

        do_op(2'b01, 32'h3FB504F3, 32'h40000000, 19, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            do_op(2'b11, $urandom, $urandom, 0, 0, 1'b0);
        do_op(2'b11, $urandom, $urandom, 2, 5, 1'b1);
        for (int i = 0; i < 30; i++)
            do_op(2'($urandom_range(3, 1)), $urandom, $urandom,
                  $urandom_range(6, 0), $urandom_range(3, 0),
                  1'($urandom));
        reset_mid_op();
        do_op(2'b11, $urandom, $urandom, 1, 0, 1'b0);
`ifdef SQ_ARB_TIMEOUT_EN
        timeout_op();
        do_op(2'b11, $urandom, $urandom, 0, 0, 1'b0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sq_arbiter.md
SQ_ARBITER -- requirements
Module: sq_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1023: maximum WAIT-state cycles before abort; valid range 1..65535.
REQ-002 CLK input 1: sole clock; all state updates on rising edge.
REQ-003 RST input 1: synchronous, active-high reset.
REQ-004 req_valid input 2: per-requester request strobe; bit0 = requester 0, bit1 = requester 1.
REQ-005 req_A0, req_A1 input 32 each: IEEE754 single-precision operands for requester 0 and requester 1.
REQ-006 req_ready output 2: per-requester accept; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-007 resp_valid output 2: per-requester response pending.
REQ-008 resp_ready input 2: per-requester response accept.
REQ-009 resp_result output 32; resp_overflow, resp_underflow, resp_err output 1 each: response payload, shared by both requesters, qualified by resp_valid.
REQ-010 dp_A output 32: operand to the shared square datapath.
REQ-011 dp_start output 1: single-cycle start pulse to the datapath.
REQ-012 dp_done input 1: datapath completion pulse, i.e. its enable output.
REQ-013 dp_result input 32; dp_overflow, dp_underflow input 1 each: datapath outputs, valid in the dp_done cycle.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, encoded in 2 bits.
REQ-015 IDLE: if any req_valid bit is set, req_ready SHALL be high for exactly one granted requester in that cycle (combinational), its operand SHALL be latched, and the FSM SHALL go to ISSUE; otherwise it SHALL remain in IDLE.
REQ-016 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not served last; after reset, requester 0 has priority.
REQ-017 req_ready SHALL be 0 in every state except IDLE.
REQ-018 ISSUE: dp_start SHALL be 1 for exactly one cycle, dp_A SHALL equal the latched operand, and the next state SHALL be WAIT.
REQ-019 dp_A SHALL hold the latched operand from ISSUE until leaving WAIT.
REQ-020 dp_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-021 WAIT: when dp_done is 1, the controller SHALL latch dp_result, dp_overflow and dp_underflow, set resp_err=0, and go to RESP.
REQ-022 RESP: resp_valid[g] SHALL be 1 for the granted requester g only, with the payload held stable.
REQ-023 When resp_ready[g] is 1 in RESP, the FSM SHALL go to IDLE and update the last-served pointer to g.
REQ-024 The minimum latency from request acceptance to resp_valid SHALL be 3 cycles: accept in cycle N, dp_start in N+1, dp_done no earlier than N+2, resp_valid in N+3.
REQ-025 The next grant SHALL occur no earlier than the cycle after the response handshake (one operation in flight).

Reset
REQ-026 While RST is high, the FSM SHALL go to IDLE and the last-served pointer SHALL select requester 1, so requester 0 has priority.
REQ-027 While RST is high, req_ready, resp_valid, dp_start, resp_overflow, resp_underflow and resp_err SHALL be 0, and dp_A and resp_result SHALL be 32'h0.
REQ-028 A reset asserted mid-operation SHALL discard the in-flight operation with no response, and a later dp_done SHALL be ignored.

Configuration
REQ-029 Macro SQ_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-030 With SQ_ARB_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES without dp_done, the controller SHALL go to RESP with resp_result=32'h7FC00000, resp_err=1 and overflow/underflow=0.
REQ-031 With SQ_ARB_TIMEOUT_EN, if dp_done arrives in the expiry cycle, dp_done SHALL win.
REQ-032 Macro not defined: no counter SHALL exist, WAIT SHALL persist until dp_done, and resp_err SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the state encoding constants, QNAN_CONST = 32'h7FC00000, and the default TIMEOUT_CYCLES.
REQ-034 One sub-module, sq_rr_arb, SHALL implement the 2-way round-robin grant: inputs req, last and en; output one-hot grant.
REQ-035 The datapath SHALL be instantiated outside this block.

Verification
REQ-036 A single request from req 0 with A=32'h3FB504F3, and a datapath model returning 32'h40000000 after 20 cycles, SHALL produce one dp_start pulse, then resp_valid=2'b01 with result 32'h40000000 and err=0.
REQ-037 req_valid=2'b11 held continuously with resp_ready tied high SHALL produce grants alternating 0,1,0,1 over four operations, with no dp_start overlap.
REQ-038 With resp_ready low for 5 cycles in RESP, the payload and resp_valid SHALL hold stable, req_ready SHALL stay 0, and a new grant SHALL follow the handshake.
REQ-039 RST pulsed during WAIT, followed by a late dp_done, SHALL cause no resp_valid, and the FSM SHALL be in IDLE with priority back at requester 0.
REQ-040 With SQ_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and dp_done never asserted, resp_valid SHALL follow 8 WAIT cycles with result 32'h7FC00000 and err=1.
REQ-041 A dp_done pulse asserted during ISSUE or IDLE SHALL be ignored, and the response SHALL use the dp_done received in WAIT.
